par_frame_rx: RTL and testbench

Parameter-frame receiver for the DRSSTC controller's parameter bus. It consumes bytes from the UART receiver and validates 4-byte frames: sync, address, data, checksum. For each valid frame it issues a single-cycle write strobe with a stable address/value pair. This bus feeds every addressed parameter sink, including the OCD level PWM, which latches the value when its enable is high and the bus address matches its own.

---
 rtl/par_bus_pkg.sv | 22 ++
 rtl/par_frame_rx_if.sv | 23 ++
 rtl/par_frame_rx_timeout.sv | 36 +++
 rtl/par_frame_rx.sv | 126 ++++++++++++
 tb/tb_par_frame_rx.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/par_bus_pkg.sv
// Parameter-bus shared definitions: sync byte, receiver states and
// width helpers used by every addressed parameter sink.
package par_bus_pkg;

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    GET_CSUM
  } state_e;

  function automatic int par_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int addr_w(input int max_addr);
    return (max_addr < 1) ? 1 : $clog2(max_addr + 1);
  endfunction

endpackage

// File: rtl/par_frame_rx_if.sv
// Byte stream in, parameter write bus out.
// master = byte source / bus observer, slave = frame receiver.
interface par_frame_rx_if #(
  parameter int PW = 8,
  parameter int AW = 3
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [PW-1:0] pw_par;
  logic [AW-1:0] addr;
  logic          en;
  logic          frame_err;

  modport master (
    output rx_data, rx_valid,
    input  pw_par, addr, en, frame_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output pw_par, addr, en, frame_err
  );
endinterface

// File: rtl/par_frame_rx_timeout.sv
// Loadable inter-byte gap counter; expired flags the last idle cycle
// of the allowed gap while the receiver is mid-frame.
module byte_timeout #(
  parameter int CLK_MHZ    = 100,
  parameter int TIMEOUT_US = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int N  = CLK_MHZ * TIMEOUT_US;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LOAD_V = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = LOAD_V;
    else if (run && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A byte arriving in the expiry cycle takes priority.
  assign expired = run && !load && (cnt_q == '0);

endmodule

// File: rtl/par_frame_rx.sv
// Parameter-frame receiver: SYNC, A, D, C=(A+D) mod 256.
// Accepted frames drive a one-cycle en with held addr/pw_par.
module par_frame_rx
  import par_bus_pkg::*;
#(
  parameter int CLK_MHZ     = 100,
  parameter int PAR_MAX_VAL = 255,
  parameter int ADDR_MAX    = 4,
  parameter int TIMEOUT_US  = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic [par_w(PAR_MAX_VAL)-1:0]  pw_par,
  output logic [addr_w(ADDR_MAX)-1:0]    addr,
  output logic                           en,
  output logic                           frame_err
);

  localparam int PW = par_w(PAR_MAX_VAL);
  localparam int AW = addr_w(ADDR_MAX);
  localparam logic [7:0] AMAX = 8'(ADDR_MAX);
  localparam logic [7:0] DMAX = 8'(PAR_MAX_VAL);

  state_e        state_q, state_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    d_q, d_d;
  logic [PW-1:0] pw_q, pw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          en_q, en_d;
  logic          err_q, err_d;
  logic          expired;
  logic [7:0]    csum;
  logic          ok;

  byte_timeout #(
    .CLK_MHZ   (CLK_MHZ),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (rx_valid),
    .run    (state_q != IDLE),
    .expired(expired)
  );

  assign csum = a_q + d_q;
  assign ok   = (rx_data == csum) && (a_q <= AMAX) && (d_q <= DMAX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    pw_d    = pw_q;
    addr_d  = addr_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == SYNC)
          state_d = GET_ADDR;
      end
      GET_ADDR: begin
        if (rx_valid) begin
          a_d     = rx_data;
          state_d = GET_DATA;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          d_d     = rx_data;
          state_d = GET_CSUM;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_CSUM: begin
        if (rx_valid) begin
          state_d = IDLE;
          if (ok) begin
            en_d   = 1'b1;
            pw_d   = d_q[PW-1:0];
            addr_d = a_q[AW-1:0];
          end else begin
            err_d  = 1'b1;
          end
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      d_q     <= '0;
      pw_q    <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pw_q    <= pw_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  assign pw_par    = pw_q;
  assign addr      = addr_q;
  assign en        = en_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_par_frame_rx.sv
// Directed bench for par_frame_rx: valid, bad checksum, range,
// timeout, noise/back-to-back and mid-frame reset.
module tb_par_frame_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  par_frame_rx_if #(.PW(8), .AW(3)) bus ();

  par_frame_rx #(
    .CLK_MHZ    (100),
    .PAR_MAX_VAL(255),
    .ADDR_MAX   (4),
    .TIMEOUT_US (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (bus.rx_data),
    .rx_valid (bus.rx_valid),
    .pw_par   (bus.pw_par),
    .addr     (bus.addr),
    .en       (bus.en),
    .frame_err(bus.frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic outs(input string tag, input logic e,
                      input logic f, input logic [7:0] p,
                      input logic [2:0] a);
    chk({tag, "_en"},   32'(bus.en),        32'(e));
    chk({tag, "_err"},  32'(bus.frame_err), 32'(f));
    chk({tag, "_pw"},   32'(bus.pw_par),    32'(p));
    chk({tag, "_addr"}, 32'(bus.addr),      32'(a));
  endtask

  initial begin
    int early;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick(3);
    outs("reset", 0, 0, 8'h00, 3'd0);
    rst_n = 1'b1;
    tick(2);

    put(8'hA5); put(8'h04); put(8'h80);
    chk("valid_pre_en", 32'(bus.en), 0);
    put(8'h84);
    outs("valid", 1, 0, 8'h80, 3'd4);
    tick(1);
    outs("valid_hold", 0, 0, 8'h80, 3'd4);

    put(8'hA5); put(8'h04); put(8'h80); put(8'h85);
    outs("badsum", 0, 1, 8'h80, 3'd4);
    tick(1);
    outs("badsum_after", 0, 0, 8'h80, 3'd4);

    put(8'hA5); put(8'h05); put(8'h10); put(8'h15);
    outs("badaddr", 0, 1, 8'h80, 3'd4);
    tick(1);

    put(8'hA5); put(8'h02);
    early = 0;
    repeat (99) begin
      tick(1);
      if (bus.frame_err || bus.en) early++;
    end
    chk("tmo_early", 32'(early), 0);
    tick(1);
    outs("tmo", 0, 1, 8'h80, 3'd4);
    tick(1);
    chk("tmo_after_err", 32'(bus.frame_err), 0);
    put(8'hA5); put(8'h02); put(8'h33); put(8'h35);
    outs("tmo_frame", 1, 0, 8'h33, 3'd2);
    tick(1);

    put(8'h11);
    chk("noise1_err", 32'(bus.frame_err), 0);
    put(8'h22);
    chk("noise2_err", 32'(bus.frame_err), 0);
    put(8'hA5); put(8'h01); put(8'h01);
    chk("b2b_pre", 32'({bus.en, bus.frame_err}), 0);
    put(8'h02);
    outs("b2b_1", 1, 0, 8'h01, 3'd1);
    put(8'hA5);
    outs("b2b_sync", 0, 0, 8'h01, 3'd1);
    put(8'h03); put(8'h07);
    chk("b2b_mid", 32'({bus.en, bus.frame_err}), 0);
    put(8'h0A);
    outs("b2b_2", 1, 0, 8'h07, 3'd3);
    tick(1);
    outs("b2b_end", 0, 0, 8'h07, 3'd3);

    put(8'hA5); put(8'h04);
    rst_n = 1'b0;
    #1;
    outs("rst_mid", 0, 0, 8'h00, 3'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    put(8'h80); put(8'h84);
    outs("rst_partial", 0, 0, 8'h00, 3'd0);
    tick(1);
    outs("rst_partial2", 0, 0, 8'h00, 3'd0);
    put(8'hA5); put(8'h04); put(8'h80); put(8'h84);
    outs("rst_full", 1, 0, 8'h80, 3'd4);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n && bus.en && bus.frame_err) begin
      n_chk++;
      n_fail++;
      $error("FAIL en_err_overlap observed=11 expected=not both");
    end
  end

endmodule
